// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer.
// Takes one branch op from decode, waits for its register operand, evaluates
// the zero / positive / negative condition and then either redirects the PC
// and flushes the front end (taken) or simply releases the pipeline (not
// taken). Keeps saturating taken / not-taken statistics.
module branch_resolve_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_func,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              opnd_valid,
    input  logic [DATA_W-1:0] opnd_data,
    input  logic              br_cancel,
    output logic              stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              flush,
    output logic              illegal_func,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       ntaken_cnt
);

    // Controller states.
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_OPND = 2'd1;
    localparam logic [1:0] RESOLVE   = 2'd2;
    localparam logic [1:0] FLUSH     = 2'd3;

    // Condition codes understood by the controller.
    localparam logic [3:0] FUNC_EQZ = 4'b0000;
    localparam logic [3:0] FUNC_GTZ = 4'b0010;
    localparam logic [3:0] FUNC_LTZ = 4'b0001;

    // The flush counter holds the FLUSH-state cycles still to go; RESOLVE
    // already supplies the first flush cycle, so it is loaded with
    // FLUSH_CYCLES-1.
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0]        state;
    logic [1:0]        stateNext;
    logic [3:0]        funcQ;
    logic [ADDR_W-1:0] targetQ;
    logic              takenQ;
    logic              illegalQ;
    logic [FCNT_W-1:0] flushCnt;
    logic [15:0]       takenCnt;
    logic [15:0]       ntakenCnt;

    logic              condTaken;
    logic              condLegal;
    logic              resolveFire;

    // RESOLVE only takes effect when an older exception is not cancelling us.
    assign resolveFire = (state == RESOLVE) && !br_cancel;

    // Evaluate the captured condition against the operand arriving this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        condTaken = 1'b0;
        condLegal = 1'b1;
        case (funcQ)
            FUNC_EQZ: condTaken = (opnd_data == '0);
            FUNC_GTZ: condTaken = !opnd_data[DATA_W-1] && (opnd_data != '0);
            FUNC_LTZ: condTaken = opnd_data[DATA_W-1];
            default:  condLegal = 1'b0;
        endcase
    end

    // Next-state selection; cancel beats an operand arriving in the same cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    stateNext = WAIT_OPND;
                end
            end
            WAIT_OPND: begin
                if (br_cancel) begin
                    stateNext = IDLE;
                end else if (opnd_valid) begin
                    stateNext = RESOLVE;
                end
            end
            RESOLVE: begin
                if (br_cancel || !takenQ) begin
                    stateNext = IDLE;
                end else if (FLUSH_CYCLES > 1) begin
                    stateNext = FLUSH;
                end else begin
                    stateNext = IDLE;
                end
            end
            FLUSH: begin
                if (flushCnt <= FCNT_ONE) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Capture the branch op at accept time.
    always_ff @(posedge clk) begin
        // NOTE: the captured op is reset as well so a cancelled or reset
        // branch can never leak a stale target or condition into RESOLVE.
        if (!rst_n) begin
            funcQ   <= '0;
            targetQ <= '0;
        end else if (state == IDLE && br_valid) begin
            funcQ   <= br_func;
            targetQ <= br_target;
        end
    end

    // Register the resolved outcome when the operand arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            takenQ   <= 1'b0;
            illegalQ <= 1'b0;
        end else if (state == WAIT_OPND && opnd_valid && !br_cancel) begin
            takenQ   <= condTaken;
            illegalQ <= !condLegal;
        end
    end

    // Flush-hold counter: loaded on a taken resolve, counts down in FLUSH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flushCnt <= '0;
        end else if (resolveFire && takenQ) begin
            flushCnt <= FLUSH_LOAD;
        end else if (state == FLUSH && flushCnt != '0) begin
            flushCnt <= flushCnt - FCNT_ONE;
        end
    end

    // Saturating taken / not-taken statistics, bumped once per resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            takenCnt  <= '0;
            ntakenCnt <= '0;
        end else if (resolveFire) begin
            if (takenQ) begin
                if (takenCnt != CNT_MAX) begin
                    takenCnt <= takenCnt + 16'd1;
                end
            end else begin
                if (ntakenCnt != CNT_MAX) begin
                    ntakenCnt <= ntakenCnt + 16'd1;
                end
            end
        end
    end

    // br_ready is also masked by rst_n so decode sees no acceptance while
    // reset is being held, even though the state is already IDLE.
    assign br_ready       = rst_n && (state == IDLE);
    assign stall          = (state != IDLE);
    assign redirect_valid = resolveFire && takenQ;
    assign redirect_addr  = redirect_valid ? targetQ : '0;
    assign flush          = redirect_valid || (state == FLUSH);
    assign illegal_func   = resolveFire && illegalQ;
    assign taken_cnt      = takenCnt;
    assign ntaken_cnt     = ntakenCnt;

endmodule
